// File: rtl/mux6_rr_arbiter_pkg.sv
// Shared types and constants for the six-way round-robin mux arbiter.
package mux_arb_pkg;
   localparam int          NUM_REQ    = 6;
   localparam int          SEL_W      = 3;
   localparam logic [2:0]  RESET_LAST = 3'd5;

   typedef enum logic {IDLE, OWN} state_e;

   function automatic logic [2:0] inc6(input logic [2:0] i);
      return (i >= 3'd5) ? 3'd0 : i + 3'd1;
   endfunction

   function automatic logic [5:0] onehot6(input logic [2:0] i);
      return 6'd1 << i;
   endfunction
endpackage

// File: rtl/mux6_rr_arbiter_rr_pick6.sv
// Combinational round-robin search: first set request at or after start, wrapping 5->0.
module rr_pick6
   import mux_arb_pkg::*;
(
   input  logic [5:0] req_i,
   input  logic [2:0] start_i,
   input  logic       excl_en_i,
   input  logic [2:0] excl_idx_i,
   output logic       found_o,
   output logic [2:0] idx_o
);
   logic [2:0] pos;

   always_comb begin
      found_o = 1'b0;
      idx_o   = 3'd0;
      pos     = start_i;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found_o && req_i[pos] && !(excl_en_i && pos == excl_idx_i)) begin
            found_o = 1'b1;
            idx_o   = pos;
         end
         pos = inc6(pos);
      end
   end
endmodule

// File: rtl/mux6_rr_arbiter.sv
// Round-robin arbiter driving the select of a 6:1 mux, with a per-grant hold limit.
module mux6_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int NUM_REQ  = 6,
   parameter int MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [SEL_W-1:0]   sel,
   output logic               busy,
   output logic               grant_chg
);
   localparam logic       HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

   state_e     state_q, state_d;
   logic [2:0] owner_q, owner_d;
   logic [2:0] last_q, last_d;
   logic [7:0] hold_q, hold_d;
   logic [5:0] grant_q, grant_d;
   logic [2:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic       chg_q, chg_d;

   logic       found;
   logic [2:0] win;
   logic [2:0] start;

   // While owning, the search always begins just past the owner and skips it.
   assign start = (state_q == OWN) ? inc6(owner_q) : inc6(last_q);

   rr_pick6 u_pick (
      .req_i      (req),
      .start_i    (start),
      .excl_en_i  (state_q == OWN),
      .excl_idx_i (owner_q),
      .found_o    (found),
      .idx_o      (win)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = OWN;
               owner_d = win;
               grant_d = onehot6(win);
               sel_d   = win;
               busy_d  = 1'b1;
               hold_d  = 8'd0;
            end
         end
         OWN: begin
            if (!req[owner_q]) begin
               last_d = owner_q;
               if (found) begin
                  owner_d = win;
                  grant_d = onehot6(win);
                  sel_d   = win;
                  hold_d  = 8'd0;
               end else begin
                  state_d = IDLE;
                  grant_d = 6'd0;
                  busy_d  = 1'b0;
                  hold_d  = 8'd0;
               end
            end else if (HOLD_EN && hold_q == HOLD_LAST) begin
               hold_d = 8'd0;
               if (found) begin
                  last_d  = owner_q;
                  owner_d = win;
                  grant_d = onehot6(win);
                  sel_d   = win;
               end
            end else if (hold_q != 8'hFF) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      chg_d = (grant_d != grant_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 3'd0;
         last_q  <= RESET_LAST;
         hold_q  <= 8'd0;
         grant_q <= 6'd0;
         sel_q   <= 3'd0;
         busy_q  <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         chg_q   <= chg_d;
      end
   end

   assign grant     = grant_q;
   assign sel       = sel_q;
   assign busy      = busy_q;
   assign grant_chg = chg_q;
endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Directed bench for mux6_rr_arbiter: vector table plus multi-cycle corner sequences.
module tb_mux6_rr_arbiter;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] req8 = '0, req4 = '0, req0 = '0;
   logic [5:0] g8, g4, g0;
   logic [2:0] s8, s4, s0;
   logic       b8, b4, b0, c8, c4, c0;
   int         n_checks = 0;
   int         n_fail   = 0;
   logic       inv_en   = 1'b0;

   always #5 clk = ~clk;

   mux6_rr_arbiter #(.NUM_REQ(6), .MAX_HOLD(8)) u8 (
      .clk(clk), .reset(reset), .req(req8), .grant(g8), .sel(s8), .busy(b8), .grant_chg(c8));
   mux6_rr_arbiter #(.NUM_REQ(6), .MAX_HOLD(4)) u4 (
      .clk(clk), .reset(reset), .req(req4), .grant(g4), .sel(s4), .busy(b4), .grant_chg(c4));
   mux6_rr_arbiter #(.NUM_REQ(6), .MAX_HOLD(0)) u0 (
      .clk(clk), .reset(reset), .req(req0), .grant(g0), .sel(s0), .busy(b0), .grant_chg(c0));

   typedef struct {
      logic [5:0] req;
      logic [5:0] grant;
      logic [2:0] sel;
      logic       busy;
      logic       chg;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Structural invariants on the MAX_HOLD=8 instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (inv_en) begin
         check("inv_onehot0", {31'd0, $onehot0(g8)}, 32'd1);
         check("inv_busy", {31'd0, b8}, {31'd0, |g8});
         if (b8) check("inv_sel", {29'd0, s8}, {29'd0, 3'(g8 == 6'd1 ? 0 : g8 == 6'd2 ? 1 :
                       g8 == 6'd4 ? 2 : g8 == 6'd8 ? 3 : g8 == 6'd16 ? 4 : 5)});
      end
   end

   initial begin
      vecs[0]  = '{6'b000000, 6'b000000, 3'd0, 1'b0, 1'b0};
      vecs[1]  = '{6'b000100, 6'b000100, 3'd2, 1'b1, 1'b1};
      vecs[2]  = '{6'b000100, 6'b000100, 3'd2, 1'b1, 1'b0};
      vecs[3]  = '{6'b000000, 6'b000000, 3'd2, 1'b0, 1'b1};
      vecs[4]  = '{6'b000000, 6'b000000, 3'd2, 1'b0, 1'b0};
      vecs[5]  = '{6'b100001, 6'b100000, 3'd5, 1'b1, 1'b1};
      vecs[6]  = '{6'b000011, 6'b000001, 3'd0, 1'b1, 1'b1};
      vecs[7]  = '{6'b000011, 6'b000001, 3'd0, 1'b1, 1'b0};
      vecs[8]  = '{6'b000010, 6'b000010, 3'd1, 1'b1, 1'b1};
      vecs[9]  = '{6'b001010, 6'b000010, 3'd1, 1'b1, 1'b0};
      vecs[10] = '{6'b001000, 6'b001000, 3'd3, 1'b1, 1'b1};
      vecs[11] = '{6'b000000, 6'b000000, 3'd3, 1'b0, 1'b1};

      // Reset values
      #2;
      check("reset_outputs", {20'd0, g8, s8, b8, c8}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      inv_en = 1'b1;

      // Vector table
      for (int i = 0; i < 12; i++) begin
         req8 = vecs[i].req;
         tick();
         check($sformatf("vec%0d", i), {21'd0, g8, s8, b8, c8},
               {21'd0, vecs[i].grant, vecs[i].sel, vecs[i].busy, vecs[i].chg});
      end

      // Fairness with all requesting: fresh priority from requester 0
      reset = 1'b1;
      #2;
      reset = 1'b0;
      req8 = 6'b111111;
      for (int k = 0; k < 35; k++) begin
         logic [2:0] es;
         es = 3'((k / 8) % 6);
         tick();
         check($sformatf("fair_k%0d", k), {22'd0, g8, s8, c8},
               {22'd0, 6'd1 << es, es, (k % 8) == 0});
      end

      // Async reset mid-hold while requester 4 owns
      check("pre_reset_grant", {26'd0, g8}, {26'd0, 6'b010000});
      reset = 1'b1;
      #1;
      check("async_reset_clear", {20'd0, g8, s8, b8, c8}, 32'd0);
      req8 = 6'b110000;
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("post_reset_first", {23'd0, g8, s8}, {23'd0, 6'b010000, 3'd4});
      for (int k = 0; k < 8; k++) tick();
      check("post_reset_rotate", {22'd0, g8, s8, c8}, {22'd0, 6'b100000, 3'd5, 1'b1});

      // Sole requester with MAX_HOLD=4 keeps the grant
      req4 = 6'b001000;
      tick();
      check("hold4_first", {22'd0, g4, s4, c4}, {22'd0, 6'b001000, 3'd3, 1'b1});
      for (int k = 0; k < 12; k++) begin
         tick();
         check($sformatf("hold4_keep%0d", k), {25'd0, g4, c4}, {25'd0, 6'b001000, 1'b0});
      end

      // Unlimited hold: requester 0 keeps 50 cycles, then 1 takes over on release
      req0 = 6'b000011;
      tick();
      check("unl_first", {22'd0, g0, s0, c0}, {22'd0, 6'b000001, 3'd0, 1'b1});
      for (int k = 1; k < 50; k++) begin
         tick();
         check($sformatf("unl_hold%0d", k), {25'd0, g0, c0}, {25'd0, 6'b000001, 1'b0});
      end
      req0 = 6'b000010;
      tick();
      check("unl_release", {22'd0, g0, s0, c0}, {22'd0, 6'b000010, 3'd1, 1'b1});

      inv_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mux6_rr_arbiter.md
Name: mux6_rr_arbiter

Overview:
- Round-robin arbiter that shares the 6:1 select mux between six requesters.
- Drives the mux's 3-bit select from a registered grant.
- Adds a one-hot grant and a per-grant hold limit so that no requester can monopolise the mux.
- Sits directly in front of the 6:1 mux; requester i is wired to mux input i.

Parameters:
NUM_REQ, 6, number of requesters; fixed at 6 (select width 3); other values unsupported.
MAX_HOLD, 8, max consecutive cycles one owner keeps the grant while others wait; 0 = unlimited; range 0..255.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
req  in  6  request vector; bit i = requester i wants the mux.
grant  out  6  one-hot grant, registered; all zero when idle.
sel  out  3  mux select = index of the granted requester, 0..5; values 6 and 7 are never driven.
busy  out  1  high while any grant is active.
grant_chg  out  1  one-cycle pulse on any cycle where grant differs from the previous cycle.

Behaviour:
- States are IDLE and OWN. Registers:
  - state
  - owner[2:0]
  - last[2:0], the most recent owner
  - hold_cnt[7:0]
- Reset (async, immediate):
  - state=IDLE, grant=0, sel=0, busy=0, grant_chg=0, last=5, hold_cnt=0.
  - last=5 makes requester 0 highest priority after reset.
- Priority search: scan indices last+1, last+2, … mod 6 (wrap 5→0). The first set req bit wins. Searching excludes the current owner when rotating.
- IDLE:
  - req==0: stay; outputs hold their reset values.
  - Otherwise: the winner W is registered. Next cycle: state=OWN, owner=W, grant=1<<W, sel=W, busy=1, grant_chg=1, hold_cnt=0.
  - Latency from req to grant is 1 clock.
- OWN, evaluated each cycle, first matching rule applies:
  1. req[owner]==0 (release):
     - last=owner.
     - If other requests exist, grant the next winner in the following cycle. There is no idle bubble, and grant_chg=1.
     - Otherwise go to IDLE: grant=0, busy=0, sel holds its last value, grant_chg=1.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (forced rotation):
     - If another req is set: last=owner, grant the next winner, hold_cnt=0, grant_chg=1.
     - Otherwise the owner keeps the grant and hold_cnt resets to 0.
  3. Else: hold_cnt++ (saturating at 255), grant unchanged, grant_chg=0.
- Simultaneous events:
  - Owner release and a new req on the same cycle: the new req takes part in the search.
  - Release and hold expiry on the same cycle: the release rule wins.
- Invariants, checked every cycle:
  - grant is one-hot or zero.
  - sel equals the index of the grant bit whenever busy=1.
  - busy == |grant.
  - A request is never granted to a requester whose req is low in the cycle the grant decision is made.
- Reset asserted mid-grant: all outputs clear immediately. After release, arbitration restarts from requester 0 priority.
- Fairness: with all six requesting continuously and MAX_HOLD=M, each requester receives exactly M cycles per 6M-cycle window.

Decomposition:
- Shared package mux_arb_pkg holds:
  - NUM_REQ=6 and SEL_W=3
  - state enum {IDLE, OWN}
  - constant RESET_LAST=3'd5
- One natural sub-module: rr_pick6, purely combinational. Inputs are req[5:0], start[2:0], and exclude-enable plus exclude index. Outputs are found and idx[2:0].
- The top instantiates rr_pick6 once and keeps the state and counters.

Test Plan:
1. Reset, then req=6'b000100 at cycle 0 → cycle 1: grant=000100, sel=2, busy=1, grant_chg=1; drop req → next cycle grant=0, busy=0.
2. req=6'b111111 held, MAX_HOLD=8 → sel sequence 0,1,2,3,4,5,0… with each value lasting exactly 8 cycles; grant_chg pulses every 8 cycles.
3. Owner 3 holds, req=6'b001000, MAX_HOLD=4 → owner stays 3 indefinitely; hold_cnt wraps 0..3; grant_chg stays 0.
4. Owner 5, then req=6'b000011 with req[5] dropped → the next cycle grants 0 (wrap-around), not idle; no bubble cycle.
5. Assert reset while grant=010000 mid-hold → outputs are zero in the same cycle. After release with req=6'b110000, the grant goes to 4 first.
6. MAX_HOLD=0, req=6'b000011 for 50 cycles → requester 0 holds all 50 cycles. On release, requester 1 is granted the next cycle.
